// File: rtl/async_fifo2_sync.sv
// Single-clock FIFO with registered occupancy flags, sticky error flags and
// a compile-time choice between registered-read and first-word-fall-through.
module async_fifo2_sync #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             flush,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_L = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AF_L    = (ASIZE + 1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_L    = (ASIZE + 1)'(AE_LEVEL);

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ASIZE:0]   level_q, level_d;
  logic             wfull_q, wfull_d, rempty_q, rempty_d;
  logic             afull_q, afull_d, aempty_q, aempty_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             wr_en, rd_en;

  // Acceptance looks only at the registered flags, so a write while full is
  // dropped even when a read is accepted on the same edge.
  assign wr_en = winc & ~wfull_q & ~flush;
  assign rd_en = rinc & ~rempty_q & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q | (winc & wfull_q);
    unf_d   = unf_q | (rinc & rempty_q);
    rdata_d = rdata_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + ASIZE'(1);
      if (rd_en) rptr_d = rptr_q + ASIZE'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + (ASIZE + 1)'(1);
        2'b01:   level_d = level_q - (ASIZE + 1)'(1);
        default: level_d = level_q;
      endcase
      if (FWFT == 0) begin
        if (rd_en) rdata_d = mem_q[rptr_q];
      end else if (level_d != '0) begin
        // The new head is the incoming word when it is the only one left.
        rdata_d = (wr_en && (rptr_d == wptr_q)) ? wdata : mem_q[rptr_d];
      end
    end
  end

  always_comb begin
    wfull_d  = (level_d == DEPTH_L);
    rempty_d = (level_d == '0);
    afull_d  = (level_d >= AF_L);
    aempty_d = (level_d <= AE_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately unreset; pointers guarantee it is never read stale.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

  assign rdata         = rdata_q;
  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_async_fifo2_sync.sv
// Bench for async_fifo2_sync: a queue-based occupancy model checked every
// cycle against a registered-read and a fall-through instance.
module tb_async_fifo2_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rinc = 1'b0;
  logic       flush = 1'b0;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, rempty0, wafull0, raempty0, ovf0, unf0;
  logic       wfull1, rempty1, wafull1, raempty1, ovf1, unf1;
  logic [4:0] level0, level1;

  int checks = 0;
  int failures = 0;
  bit cmpEn = 1'b0;

  logic [7:0] mq[$];
  logic       mOv, mUn;
  logic [7:0] mRd0, mRd1;

  async_fifo2_sync #(.FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .flush(flush), .rdata(rdata0), .wfull(wfull0), .rempty(rempty0),
    .walmost_full(wafull0), .ralmost_empty(raempty0), .level(level0),
    .overflow(ovf0), .underflow(unf0)
  );

  async_fifo2_sync #(.FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .flush(flush), .rdata(rdata1), .wfull(wfull1), .rempty(rempty1),
    .walmost_full(wafull1), .ralmost_empty(raempty1), .level(level1),
    .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOv  = 1'b0;
    mUn  = 1'b0;
    mRd0 = 8'h00;
    mRd1 = 8'h00;
  endtask

  // One rising edge of the behavioural model, from the inputs now applied.
  task automatic modelEdge();
    bit full, empty;
    if (!rst_n) begin
      modelReset();
    end else if (flush) begin
      mq.delete();
      mOv = 1'b0;
      mUn = 1'b0;
    end else begin
      full  = (mq.size() == 16);
      empty = (mq.size() == 0);
      if (winc && full) mOv = 1'b1;
      if (rinc && empty) mUn = 1'b1;
      if (rinc && !empty) mRd0 = mq.pop_front();
      if (winc && !full) mq.push_back(wdata);
      if (mq.size() > 0) mRd1 = mq[0];
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic f);
    winc  = w;
    wdata = d;
    rinc  = r;
    flush = f;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    winc  = 1'b0;
    rinc  = 1'b0;
    flush = 1'b0;
  endtask

  // Every cycle: all outputs of both instances against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("level",         {27'd0, level0},  mq.size());
      checkOutput("wfull",         {31'd0, wfull0},  {31'd0, mq.size() == 16});
      checkOutput("rempty",        {31'd0, rempty0}, {31'd0, mq.size() == 0});
      checkOutput("walmost_full",  {31'd0, wafull0}, {31'd0, mq.size() >= 14});
      checkOutput("ralmost_empty", {31'd0, raempty0}, {31'd0, mq.size() <= 2});
      checkOutput("overflow",      {31'd0, ovf0},    {31'd0, mOv});
      checkOutput("underflow",     {31'd0, unf0},    {31'd0, mUn});
      checkOutput("rdata_reg",     {24'd0, rdata0},  {24'd0, mRd0});
      checkOutput("rdata_fwft",    {24'd0, rdata1},  {24'd0, mRd1});
      checkOutput("level_fwft",    {27'd0, level1},  mq.size());
      checkOutput("flags_fwft",    {26'd0, wfull1, rempty1, wafull1, raempty1, ovf1, unf1},
                  {26'd0, mq.size() == 16, mq.size() == 0, mq.size() >= 14, mq.size() <= 2, mOv, mUn});
    end
  end

  initial begin
    modelReset();
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    cmpEn = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("reset_level",  {27'd0, level0},  32'd0);
    checkOutput("reset_rempty", {31'd0, rempty0}, 32'd1);
    checkOutput("reset_rdata",  {24'd0, rdata0},  32'd0);
    rst_n = 1'b1;

    // Fill to full, then one dropped write.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) checkOutput("afull_at13", {31'd0, wafull0}, 32'd0);
      if (i == 13) checkOutput("afull_at14", {31'd0, wafull0}, 32'd1);
    end
    checkOutput("full_level", {27'd0, level0}, 32'd16);
    checkOutput("full_wfull", {31'd0, wfull0}, 32'd1);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("ovf_set",    {31'd0, ovf0},   32'd1);
    checkOutput("ovf_level",  {27'd0, level0}, 32'd16);

    // Drain in order, then one read too many.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_data", {24'd0, rdata0}, 32'(i));
      if (i == 12) checkOutput("aempty_at3", {31'd0, raempty0}, 32'd0);
      if (i == 13) checkOutput("aempty_at2", {31'd0, raempty0}, 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf_set",   {31'd0, unf0},   32'd1);
    checkOutput("unf_rdata", {24'd0, rdata0}, 32'h0F);
    checkOutput("unf_empty", {31'd0, rempty0}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush_unf", {31'd0, unf0}, 32'd0);

    // Steady state at level 8 across several pointer wraps.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0);
      checkOutput("wrap_level", {27'd0, level0}, 32'd8);
      checkOutput("wrap_data",  {24'd0, rdata0},
                  (i < 8) ? 32'h80 + 32'(i) : 32'h90 + 32'(i - 8));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Fall-through visibility of a single word.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("fwft_data",   {24'd0, rdata1},  32'hA5);
    checkOutput("fwft_rempty", {31'd0, rempty1}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fwft_pop_empty", {31'd0, rempty1}, 32'd1);
    checkOutput("fwft_hold",      {24'd0, rdata1},  32'hA5);

    // Flush wins over a simultaneous write.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pre_flush_level", {27'd0, level0}, 32'd10);
    checkOutput("pre_flush_ovf",   {31'd0, ovf0},   32'd1);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("flush_level",  {27'd0, level0},  32'd0);
    checkOutput("flush_rempty", {31'd0, rempty0}, 32'd1);
    checkOutput("flush_ovf",    {31'd0, ovf0},    32'd0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_flush_data", {24'd0, rdata0}, 32'h11);

    // Asynchronous reset between edges at level 5.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    checkOutput("pre_rst_level", {27'd0, level0}, 32'd5);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_level",  {27'd0, level0},  32'd0);
    checkOutput("async_rst_rempty", {31'd0, rempty0}, 32'd1);
    checkOutput("async_rst_rdata",  {24'd0, rdata0},  32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    checkOutput("rst_ignores_winc", {27'd0, level0}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_rst_data", {24'd0, rdata0}, 32'h3C);

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
